// File: rtl/fifo_read_ctrl_pkg.sv
// Shared definitions for the async-FIFO read-side controller.
// Contents: state encoding for the controller FSM, output buffer depth.
package fifo_read_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Downstream valid/ready stream carrying words drained from the FIFO.
// Signals: data (word), valid (data holds a word), ready (consumer accepts).
// master: the producer (fifo_read_ctrl). slave: the downstream consumer.
interface fifo_read_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry in-order output buffer between the FIFO read port and the
// downstream stream. Absorbs the FIFO's registered read latency plus
// backpressure.
// Ports: clk/rst (sync active-high), push/din (write tail), pop (drop head),
//        dout (head entry), occ (0..2 entries), valid (occ != 0).
module rd_skid_buf
  import fifo_read_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       occ,
  output logic             valid
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             do_pop;

  always_comb begin
    do_pop = pop && (occ_q != 2'd0);
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, do_pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = din;
        else               tail_d = din;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever stays.
        if (occ_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign dout  = head_q;
  assign occ   = occ_q;
  assign valid = (occ_q != 2'd0);

  // The read credit check upstream must make a third entry impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !do_pop && (occ_q == 2'(BUF_DEPTH))));

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the async FIFO (read clock domain only).
// Drains a requested burst of words from the FIFO read port into a
// downstream valid/ready stream through a 2-entry buffer.
// Ports: rclk/rrst (sync active-high reset), start/burst_len (request,
//        sampled in IDLE), rempty/rinc/rdata (FIFO read port, rdata valid
//        the cycle after rinc), m (downstream stream, master side),
//        busy (READ or DRAIN), done (1-cycle completion pulse),
//        rd_count (words delivered since reset, wrapping).
module fifo_read_ctrl
  import fifo_read_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = 8,
  parameter int CW    = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  start,
  input  logic [LW-1:0]         burst_len,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic [WIDTH-1:0]      rdata,
  fifo_read_ctrl_if.master      m,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         rd_count
);

  rd_state_e        state_q, state_d;
  logic [LW-1:0]    remaining_q, remaining_d;
  logic             inflight_q, inflight_d;
  logic [CW-1:0]    rd_count_q, rd_count_d;
  logic [1:0]       occ;
  logic             buf_valid;
  logic [WIDTH-1:0] buf_dout;
  logic             pop;
  logic [2:0]       level;

  rd_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk   (rclk),
    .rst   (rrst),
    .push  (inflight_q),
    .din   (rdata),
    .pop   (pop),
    .dout  (buf_dout),
    .occ   (occ),
    .valid (buf_valid)
  );

  assign m.valid = buf_valid;
  assign m.data  = buf_dout;
  assign pop     = buf_valid && m.ready;

  // Buffer slots committed by the end of this cycle; pop implies occ >= 1,
  // so the subtraction never underflows.
  assign level = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

  always_ff @(posedge rclk) begin
    if (rrst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (burst_len != '0) ? READ : DONE;
      READ:    if (remaining_q == '0) state_d = DRAIN;
      DRAIN:   if ((occ == 2'd0) && !inflight_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rinc = (state_q == READ) && !rempty && (remaining_q != '0) && (level < 3'd2);
    busy = (state_q == READ) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  always_comb begin
    remaining_d = remaining_q;
    if ((state_q == IDLE) && start) remaining_d = burst_len;
    else if (rinc)                  remaining_d = remaining_q - 1'b1;
    inflight_d = rinc;
    rd_count_d = rd_count_q + {{(CW-1){1'b0}}, pop};
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      rd_count_q  <= '0;
    end else begin
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      rd_count_q  <= rd_count_d;
    end
  end

  assign rd_count = rd_count_q;

endmodule
